// File: rtl/volume_pkg.sv
// Shared types and constants for the volume ramp sequencer.
package volume_pkg;

    localparam int unsigned     VOL_W     = 16;
    localparam logic [VOL_W-1:0] VOL_MAX   = 16'h7FFC;
    localparam logic [VOL_W-1:0] Q14_UNITY = 16'h4000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } vol_state_e;

    // Clamp a signed request into [0, vmax].
    function automatic logic [31:0] clamp_vol(input logic signed [31:0] v,
                                              input logic [31:0]        vmax);
        if (v < 0) begin
            return '0;
        end
        if (v > $signed(vmax)) begin
            return vmax;
        end
        return v;
    endfunction

endpackage

// File: rtl/volramp_step_unit.sv
// Combinational target clamp and one no-overshoot step of the applied volume toward the target.
module volramp_step_unit import volume_pkg::*; #(
    parameter int unsigned  W    = 16,
    parameter logic [W-1:0] VMAX = W'(VOL_MAX)
) (
    input  logic [W-1:0] target_vol,
    input  logic         mute,
    input  logic [W-1:0] cur_vol,
    input  logic [W-1:0] eff_vol,
    input  logic [W-1:0] ramp_step,
    output logic [W-1:0] eff_c,
    output logic [W-1:0] step_vol_c,
    output logic         reach_c
);

    localparam int unsigned XW = W + 1;

    logic signed [31:0] target_sx;
    logic [XW-1:0]      cur_x;
    logic [XW-1:0]      eff_x;
    logic [XW-1:0]      step_x;
    logic [XW-1:0]      diff_x;
    logic [XW-1:0]      move_x;
    logic               up_c;

    assign target_sx = 32'(signed'(target_vol));
    assign eff_c     = mute ? '0 : W'(clamp_vol(target_sx, 32'(VMAX)));

    // One extra bit keeps the magnitude and the moved value free of wrap.
    assign cur_x  = {1'b0, cur_vol};
    assign eff_x  = {1'b0, eff_vol};
    assign step_x = {1'b0, ramp_step};
    assign up_c   = eff_x > cur_x;
    assign diff_x = up_c ? (eff_x - cur_x) : (cur_x - eff_x);

    // A zero step lands on the target rather than stalling the ramp.
    assign reach_c    = (diff_x <= step_x) || (ramp_step == '0);
    assign move_x     = up_c ? (cur_x + step_x) : (cur_x - step_x);
    assign step_vol_c = reach_c ? eff_vol : W'(move_x);

endmodule

// File: rtl/volume_ramp_sequencer.sv
// Ramps the applied volume toward a clamped/muted target at a programmable rate.
// Optional VOLRAMP_ZC_EN holds each due step until a zero crossing of S_AXIS (or a timeout).
module volume_ramp_sequencer #(
    parameter int unsigned                 VAXIS_DATA_WIDTH = 16,
    parameter int unsigned                 AXIS_TDATA_WIDTH = 32,
    parameter int unsigned                 AXIS_DATA_WIDTH  = 16,
    parameter int unsigned                 DIV_WIDTH        = 16,
    parameter logic [VAXIS_DATA_WIDTH-1:0] VOL_MAX          = VAXIS_DATA_WIDTH'(volume_pkg::VOL_MAX),
    parameter logic [VAXIS_DATA_WIDTH-1:0] INIT_VOL         = '0,
    parameter int unsigned                 ZC_TIMEOUT       = 1024
) (
    input  logic                        a_clk,
    input  logic                        a_resetn,
    input  logic [VAXIS_DATA_WIDTH-1:0] target_vol,
    input  logic [VAXIS_DATA_WIDTH-1:0] ramp_step,
    input  logic [DIV_WIDTH-1:0]        ramp_div,
    input  logic                        mute,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [VAXIS_DATA_WIDTH-1:0] SV_AXIS_tdata,
    output logic                        SV_AXIS_tvalid,
    output logic                        busy,
    output logic                        settled
);

    import volume_pkg::*;

    localparam int unsigned W = VAXIS_DATA_WIDTH;

    vol_state_e           state_q;
    vol_state_e           state_d;
    logic [W-1:0]         vol_d;
    logic [W-1:0]         eff_q;
    logic [W-1:0]         eff_d_c;
    logic [W-1:0]         step_vol_c;
    logic                 reach_c;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 settled_d;
    logic                 step_due;

    volramp_step_unit #(
        .W    (W),
        .VMAX (VOL_MAX)
    ) u_step (
        .target_vol (target_vol),
        .mute       (mute),
        .cur_vol    (SV_AXIS_tdata),
        .eff_vol    (eff_q),
        .ramp_step  (ramp_step),
        .eff_c      (eff_d_c),
        .step_vol_c (step_vol_c),
        .reach_c    (reach_c)
    );

`ifdef VOLRAMP_ZC_EN
    localparam int unsigned ZW = $clog2(ZC_TIMEOUT + 1);

    logic          sign_q;
    logic          sign_vld_q;
    logic          zc_c;
    logic          pend_q;
    logic          pend_d;
    logic [ZW-1:0] zc_wait_q;
    logic [ZW-1:0] zc_wait_d;
    logic          unused_zc;

    // Sign of the sample's MSB, compared across consecutive valid samples.
    assign zc_c      = S_AXIS_tvalid && sign_vld_q && (S_AXIS_tdata[AXIS_TDATA_WIDTH-1] != sign_q);
    assign unused_zc = ^{S_AXIS_tdata[AXIS_TDATA_WIDTH-2:0], 32'(AXIS_DATA_WIDTH)};

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            sign_q     <= 1'b0;
            sign_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            zc_wait_q  <= '0;
        end else begin
            if (S_AXIS_tvalid) begin
                sign_q     <= S_AXIS_tdata[AXIS_TDATA_WIDTH-1];
                sign_vld_q <= 1'b1;
            end
            pend_q    <= pend_d;
            zc_wait_q <= zc_wait_d;
        end
    end
`else
    logic unused_zc;

    assign unused_zc = ^{S_AXIS_tdata, S_AXIS_tvalid, 32'(ZC_TIMEOUT), 32'(AXIS_DATA_WIDTH)};
`endif

    // Next-state, divider and step decision.
    always_comb begin
        state_d   = state_q;
        vol_d     = SV_AXIS_tdata;
        cnt_d     = cnt_q;
        settled_d = 1'b0;
        step_due  = 1'b0;
`ifdef VOLRAMP_ZC_EN
        pend_d    = pend_q;
        zc_wait_d = zc_wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (eff_q != SV_AXIS_tdata) begin
                    if (ramp_step == '0) begin
                        vol_d     = eff_q;
                        settled_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RAMP: begin
                if (eff_q == SV_AXIS_tdata) begin
                    state_d = ST_IDLE;
`ifdef VOLRAMP_ZC_EN
                    pend_d  = 1'b0;
`endif
                end else begin
`ifdef VOLRAMP_ZC_EN
                    // Divider is frozen while a due step waits for a crossing.
                    if (pend_q) begin
                        if (zc_c || (zc_wait_q == ZW'(ZC_TIMEOUT - 1))) begin
                            step_due = 1'b1;
                        end else begin
                            zc_wait_d = zc_wait_q + ZW'(1);
                        end
                    end else if (cnt_q == ramp_div) begin
                        cnt_d = '0;
                        if (zc_c) begin
                            step_due = 1'b1;
                        end else begin
                            pend_d    = 1'b1;
                            zc_wait_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                    if (step_due) begin
                        pend_d = 1'b0;
                    end
`else
                    if (cnt_q == ramp_div) begin
                        cnt_d    = '0;
                        step_due = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
`endif
                    if (step_due) begin
                        vol_d = step_vol_c;
                        if (reach_c) begin
                            settled_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q        <= ST_IDLE;
            SV_AXIS_tdata  <= INIT_VOL;
            SV_AXIS_tvalid <= 1'b0;
            busy           <= 1'b0;
            settled        <= 1'b0;
            eff_q          <= INIT_VOL;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            SV_AXIS_tdata  <= vol_d;
            SV_AXIS_tvalid <= 1'b1;
            busy           <= (state_d == ST_RAMP);
            settled        <= settled_d;
            eff_q          <= eff_d_c;
            cnt_q          <= cnt_d;
        end
    end

endmodule

// File: tb/tb_volume_ramp_sequencer.sv
// Self-checking bench: directed ramps plus randomized targets against a behavioural volume model.
module tb_volume_ramp_sequencer;

    logic        a_clk    = 1'b0;
    logic        a_resetn = 1'b0;
    logic [15:0] target_vol = '0;
    logic [15:0] ramp_step  = '0;
    logic [15:0] ramp_div   = '0;
    logic        mute       = 1'b0;
    logic [31:0] S_AXIS_tdata  = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic [15:0] SV_AXIS_tdata;
    logic        SV_AXIS_tvalid;
    logic        busy;
    logic        settled;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: applied volume, registered target, ramp flag, cycles since last step.
    int m_vol  = 0;
    int m_eff  = 0;
    int m_wait = 0;
    bit m_ramp   = 1'b0;
    bit m_settle = 1'b0;
    bit m_valid  = 1'b0;

    volume_ramp_sequencer dut (
        .a_clk          (a_clk),
        .a_resetn       (a_resetn),
        .target_vol     (target_vol),
        .ramp_step      (ramp_step),
        .ramp_div       (ramp_div),
        .mute           (mute),
        .S_AXIS_tdata   (S_AXIS_tdata),
        .S_AXIS_tvalid  (S_AXIS_tvalid),
        .SV_AXIS_tdata  (SV_AXIS_tdata),
        .SV_AXIS_tvalid (SV_AXIS_tvalid),
        .busy           (busy),
        .settled        (settled)
    );

    always #5 a_clk = ~a_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    task automatic wait_vol(input logic [15:0] v, input int lim, input string name);
        for (int i = 0; i < lim; i++) begin
            @(negedge a_clk);
            if (SV_AXIS_tdata == v) break;
        end
        chk(name, 32'(SV_AXIS_tdata), 32'(v));
    endtask

    // Behavioural reference: what the applied volume must be after each edge.
    initial forever begin
        int t;
        int e_new;
        int d;
        int stp;
        @(posedge a_clk or negedge a_resetn);
        if (!a_resetn) begin
            m_vol = 0; m_eff = 0; m_wait = 0;
            m_ramp = 1'b0; m_settle = 1'b0; m_valid = 1'b0;
        end else begin
            t     = $signed(target_vol);
            e_new = mute ? 0 : ((t < 0) ? 0 : ((t > 'h7FFC) ? 'h7FFC : t));
            stp   = int'(ramp_step);
            m_settle = 1'b0;
            m_valid  = 1'b1;
            if (m_ramp) begin
                if (m_eff == m_vol) begin
                    m_ramp = 1'b0;
                end else if (m_wait == int'(ramp_div)) begin
                    m_wait = 0;
                    d = (m_eff > m_vol) ? (m_eff - m_vol) : (m_vol - m_eff);
                    if (stp == 0 || d <= stp) begin
                        m_vol = m_eff; m_settle = 1'b1; m_ramp = 1'b0;
                    end else begin
                        m_vol = m_vol + ((m_eff > m_vol) ? stp : -stp);
                    end
                end else begin
                    m_wait++;
                end
            end else if (m_eff != m_vol) begin
                if (stp == 0) begin
                    m_vol = m_eff; m_settle = 1'b1;
                end else begin
                    m_ramp = 1'b1; m_wait = 0;
                end
            end
            m_eff = e_new;
        end
    end

    // Every out-of-reset cycle: DUT outputs against the model.
    initial forever begin
        @(negedge a_clk);
        if (a_resetn) begin
            chk("tdata",   32'(SV_AXIS_tdata),  32'(m_vol));
            chk("tvalid",  32'(SV_AXIS_tvalid), 32'(m_valid));
            chk("busy",    32'(busy),           32'(m_ramp));
            chk("settled", 32'(settled),        32'(m_settle));
        end
    end

    // Monitored signal is ignored in the default build; keep it moving anyway.
    initial forever begin
        @(negedge a_clk);
        S_AXIS_tdata  = $urandom;
        S_AXIS_tvalid = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int nset;
        int vmin;
        int k;

        // Reset values
        cyc(3);
        chk("rst_tdata",   32'(SV_AXIS_tdata),  32'h0);
        chk("rst_tvalid",  32'(SV_AXIS_tvalid), 32'h0);
        chk("rst_busy",    32'(busy),           32'h0);
        chk("rst_settled", 32'(settled),        32'h0);
        a_resetn = 1'b1;
        chk("tvalid_pre_edge", 32'(SV_AXIS_tvalid), 32'h0);
        cyc(1);
        chk("tvalid_first_edge", 32'(SV_AXIS_tvalid), 32'h1);

        // Ramp up 0 -> 0x4000 by 0x1000 every 4 cycles
        target_vol = 16'h4000; ramp_step = 16'h1000; ramp_div = 16'd3;
        nset = 0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge a_clk);
            if (settled) nset++;
            if (i == 5)  begin chk("up_wait_busy", 32'(busy), 32'h1); chk("up_wait_vol", 32'(SV_AXIS_tdata), 32'h0); end
            if (i == 6)  chk("up_step1", 32'(SV_AXIS_tdata), 32'h1000);
            if (i == 10) chk("up_step2", 32'(SV_AXIS_tdata), 32'h2000);
            if (i == 14) chk("up_step3", 32'(SV_AXIS_tdata), 32'h3000);
            if (i == 17) chk("up_hold",  32'(SV_AXIS_tdata), 32'h3000);
            if (i == 18) begin chk("up_step4", 32'(SV_AXIS_tdata), 32'h4000); chk("up_busy_fall", 32'(busy), 32'h0); end
        end
        chk("up_settled_once", 32'(nset), 32'd1);

        // Ramp down 0x4000 -> 0x0100 by 0x0300 every cycle, no undershoot
        target_vol = 16'h0100; ramp_step = 16'h0300; ramp_div = 16'd0;
        nset = 0; vmin = 'hFFFF;
        for (int i = 1; i <= 24; i++) begin
            @(negedge a_clk);
            if (settled) nset++;
            if (int'(SV_AXIS_tdata) < vmin) vmin = int'(SV_AXIS_tdata);
            if (i == 3)  chk("dn_step1",  32'(SV_AXIS_tdata), 32'h3D00);
            if (i == 4)  chk("dn_step2",  32'(SV_AXIS_tdata), 32'h3A00);
            if (i == 22) chk("dn_step20", 32'(SV_AXIS_tdata), 32'h0400);
            if (i == 23) chk("dn_land",   32'(SV_AXIS_tdata), 32'h0100);
        end
        chk("dn_settled_once", 32'(nset), 32'd1);
        chk("dn_no_undershoot", 32'(vmin), 32'h0100);

        // Immediate jumps with ramp_step = 0; negative target clamps to 0
        target_vol = 16'h2000; ramp_step = 16'h0000;
        cyc(1);
        chk("jump_not_yet", 32'(SV_AXIS_tdata), 32'h0100);
        cyc(1);
        chk("jump_vol", 32'(SV_AXIS_tdata), 32'h2000);
        chk("jump_settled", 32'(settled), 32'h1);
        target_vol = 16'h8000;
        cyc(2);
        chk("neg_target_zero", 32'(SV_AXIS_tdata), 32'h0);

        // Mute mid-ramp reverses toward 0
        target_vol = 16'h7000; ramp_step = 16'h1000; ramp_div = 16'd1;
        wait_vol(16'h3000, 40, "mute_reach_3000");
        mute = 1'b1;
        cyc(1);
        chk("mute_hold", 32'(SV_AXIS_tdata), 32'h3000);
        cyc(1);
        chk("mute_reverse", 32'(SV_AXIS_tdata), 32'h2000);
        wait_vol(16'h0000, 20, "mute_to_zero");

        // Over-range target clamps to VOL_MAX, then back to 0
        mute = 1'b0; target_vol = 16'h7FFF; ramp_step = 16'h2000; ramp_div = 16'd0;
        wait_vol(16'h7FFC, 30, "clamp_vol_max");
        cyc(3);
        chk("clamp_stays", 32'(SV_AXIS_tdata), 32'h7FFC);
        target_vol = 16'h8000;
        wait_vol(16'h0000, 30, "neg_ramp_zero");

        // Asynchronous reset mid-ramp
        target_vol = 16'h4000; ramp_step = 16'h0400; ramp_div = 16'd2;
        wait_vol(16'h2400, 100, "reach_2400");
        #2 a_resetn = 1'b0;
        #1;
        chk("async_rst_tdata",  32'(SV_AXIS_tdata),  32'h0);
        chk("async_rst_tvalid", 32'(SV_AXIS_tvalid), 32'h0);
        chk("async_rst_busy",   32'(busy),           32'h0);
        cyc(2);
        a_resetn = 1'b1;
        chk("rerst_tvalid_pre", 32'(SV_AXIS_tvalid), 32'h0);
        cyc(1);
        chk("rerst_tvalid", 32'(SV_AXIS_tvalid), 32'h1);

        // Randomized targets, mutes, steps and occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            k = $urandom_range(0, 9);
            case (k)
                4:       target_vol = 16'h7FFA + 16'($urandom_range(0, 5));
                5:       target_vol = 16'h8000 + 16'($urandom_range(0, 255));
                6:       target_vol = 16'hFFFF;
                7:       target_vol = 16'h0000;
                8:       target_vol = 16'($urandom_range(0, 16'h7FFC));
                default: target_vol = 16'($urandom_range(0, 16'hFFFF));
            endcase
            k = $urandom_range(0, 7);
            if (k == 0)      ramp_step = 16'h0000;
            else if (k <= 4) ramp_step = 16'($urandom_range(1, 16'h0400));
            else if (k <= 6) ramp_step = 16'($urandom_range(16'h0400, 16'h4000));
            else             ramp_step = 16'hFFFF;
            mute = ($urandom_range(0, 5) == 0);
            if (!m_ramp) ramp_div = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) begin
                a_resetn = 1'b0;
                cyc(2);
                a_resetn = 1'b1;
            end
            cyc($urandom_range(1, 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/volume_ramp_sequencer.md
Name: volume_ramp_sequencer

Overview:
- Generates the volume/gain stream SV_AXIS that feeds the 16x14 volume multiplier.
- Steps the applied volume toward a programmed target at a programmable rate, so gain changes and mutes produce no clicks.
- Sits between the PS/config register bank and the volume adjuster, all in the a_clk domain.
- Optionally restricts steps to zero crossings of the signal being scaled.

Parameters:
- VAXIS_DATA_WIDTH, 16: width of the volume word.
- AXIS_TDATA_WIDTH, 32: width of the monitored signal stream.
- AXIS_DATA_WIDTH, 16: bit offset of the signal sample within S_AXIS_tdata; the sample is bits [AXIS_TDATA_WIDTH-1:AXIS_DATA_WIDTH].
- DIV_WIDTH, 16: width of the step-interval divider.
- VOL_MAX, 16'h7FFC: upper clamp for the volume (Q14-aligned full scale).
- INIT_VOL, 0: volume value after reset.
- ZC_TIMEOUT, 1024: with the ZC feature, the number of cycles a step may wait for a zero crossing.

Ports:
- a_clk  in  1  block clock.
- a_resetn  in  1  asynchronous, active-low reset.
- target_vol  in  VAXIS_DATA_WIDTH  requested volume, signed. Values below 0 clamp to 0; values above VOL_MAX clamp to VOL_MAX.
- ramp_step  in  VAXIS_DATA_WIDTH  unsigned magnitude per step. 0 means an immediate jump.
- ramp_div  in  DIV_WIDTH  step interval: one step every ramp_div+1 cycles.
- mute  in  1  while high, the effective target is 0.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  monitored signal; used only with the ZC feature.
- S_AXIS_tvalid  in  1  qualifies S_AXIS_tdata.
- SV_AXIS_tdata  out  VAXIS_DATA_WIDTH  applied volume, registered.
- SV_AXIS_tvalid  out  1  volume valid.
- busy  out  1  high while the state is RAMP.
- settled  out  1  one-cycle pulse when the applied volume reaches the effective target.

Behaviour:
- Clock and reset:
  - Clock is a_clk. Reset is asynchronous and active-low on a_resetn.
  - Every flop is cleared asynchronously by a_resetn.
- Reset values:
  - SV_AXIS_tdata = INIT_VOL, SV_AXIS_tvalid = 0, busy = 0, settled = 0, state = IDLE, divider counter = 0.
  - SV_AXIS_tvalid goes to 1 on the first a_clk edge after reset release and stays 1.
- Effective target (eff):
  - eff = 0 if mute is high, otherwise clamp(target_vol, 0, VOL_MAX).
  - eff is registered, so it lags its inputs by 1 cycle.
- States: IDLE, RAMP.
- IDLE:
  - If eff != current and ramp_step == 0: set current = eff on the next edge, pulse settled, stay in IDLE.
  - If eff != current and ramp_step != 0: go to RAMP and clear the counter.
- RAMP:
  - The counter increments each cycle.
  - When counter == ramp_div, a step is due and the counter returns to 0.
  - On a step:
    - If |eff - current| <= ramp_step: current = eff, pulse settled, go to IDLE.
    - Otherwise move current toward eff by ramp_step.
  - Step arithmetic uses VAXIS_DATA_WIDTH+1 bits and never overshoots or wraps.
  - If eff becomes equal to current before a step is due: go to IDLE on that cycle without pulsing settled.
- Latency:
  - The first step lands ramp_div+1 cycles after entering RAMP.
  - SV_AXIS_tdata changes on the step edge.
- Mid-ramp changes:
  - A change of target or mute mid-ramp redirects at the next step; the counter is not restarted.
  - A change of ramp_step or ramp_div takes effect at the next comparison.
  - mute asserted during a ramp up reverses the ramp toward 0.
- Reset asserted mid-ramp returns SV_AXIS_tdata to INIT_VOL immediately (asynchronously).
- SV_AXIS has no tready; the consumer samples every cycle.

Optional Feature:
- Macro: VOLRAMP_ZC_EN.
- Defined:
  - A due step is held pending until a zero crossing of the signal: the sign bit of the S_AXIS sample differs between two consecutive tvalid-qualified samples.
  - The pending step then executes on the crossing edge.
  - If no crossing arrives within ZC_TIMEOUT cycles of the step falling due, the step executes anyway.
  - The divider counter does not run while a step is pending.
- Undefined:
  - The S_AXIS inputs are ignored and steps execute exactly on divider expiry.
  - ZC_TIMEOUT is unused.

Decomposition:
- Shared package (volume_pkg) holds:
  - the state enum (IDLE, RAMP);
  - VOL_MAX, the Q14 unity constant 16'h4000 and the clamp function.
- One natural sub-module: volramp_step_unit, the combinational clamp and the step-toward-target with no-overshoot.
- The FSM, divider and ZC logic stay in the top module.

Test Plan:
1. Reset, then target_vol=0x4000, ramp_step=0x1000, ramp_div=3: volume reads 0x1000, 0x2000, 0x3000, 0x4000 at 4-cycle spacing, first step 4 cycles after RAMP entry; settled pulses once; busy then falls.
2. Current 0x4000, ramp_step=0x0300, target 0x0100, ramp_div=0: volume 0x3D00, 0x3A00, … down to 0x0400, then exactly 0x0100 with no undershoot; settled pulses once.
3. Ramp up toward 0x7000, assert mute when volume reaches 0x3000: ramp reverses to 0 at the same rate.
4. target_vol=0x8000 (negative) gives final volume 0; target_vol=0x7FFF gives final volume 0x7FFC; ramp_step=0 with target 0x2000 jumps the next cycle.
5. Pull a_resetn low mid-ramp at volume 0x2400: SV_AXIS_tdata reads 0 and tvalid reads 0 within the same cycle, with no clock edge required.
6. VOLRAMP_ZC_EN, square-wave signal with a 100-cycle period: each step coincides with a sign flip. With the signal held constant, each step executes ZC_TIMEOUT cycles after falling due.
